// File: rtl/spi_master_burst.sv
// Burst SPI master: parametrised word width, one-hot chip selects,
// MSB/LSB-first, CS held across words of a valid/ready stream.
module spi_master_burst #(
  parameter int DATA_W = 8,
  parameter int CS_NUM = 4,
  parameter int CS_W   = 2,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DIV_W-1:0]  clk_divisor,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_last,
  output logic              busy,
  output logic [CS_NUM-1:0] spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int BW   = $clog2(2*DATA_W) + 1;
  localparam int LAST = 2*DATA_W - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_NEXT, S_HOLD, S_GUARD
  } state_t;

  state_t state, state_nx;

  logic              cpol_r, cpha_r, lsb_r, last_r;
  logic [DIV_W-1:0]  div_r, cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_nx, word_in;
  logic              running, tick, hs, load;
  logic              last_edge, sample, drive;
  logic              lsb_sel, cpha_sel;

  function automatic logic [DATA_W-1:0] rev(
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++)
      r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  // Out-of-range selects decode to no active chip select.
  function automatic logic [CS_NUM-1:0] cs_dec(
    input logic [CS_W-1:0] s
  );
    logic [CS_NUM-1:0] r;
    r = '1;
    for (int i = 0; i < CS_NUM; i++)
      if (s == CS_W'(i)) r[i] = 1'b0;
    return r;
  endfunction

  assign running = (state == S_SETUP) ||
                   (state == S_SHIFT) ||
                   (state == S_HOLD)  ||
                   (state == S_GUARD);
  assign tick = running &&
                (cnt == div_r - DIV_W'(1));
  assign hs   = tx_valid && tx_ready;
  assign load = hs && ((state == S_IDLE) ||
                       (state == S_NEXT));

  assign lsb_sel  = (state == S_IDLE) ? lsb_first_i : lsb_r;
  assign cpha_sel = (state == S_IDLE) ? cpha_i : cpha_r;
  assign word_in  = lsb_sel ? rev(tx_data) : tx_data;

  assign last_edge = (state == S_SHIFT) &&
                     (bit_cnt == BW'(LAST));
  // Even edge index is the leading edge.
  assign sample = (bit_cnt[0] == cpha_r);
  assign drive  = !sample && !last_edge;
  assign rx_nx  = sample ?
                  ((rx_sh << 1) | DATA_W'(spi_miso)) :
                  rx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (hs) state_nx = S_SETUP;
      S_NEXT:  if (hs) state_nx = S_SETUP;
      S_SETUP: if (tick) state_nx = S_SHIFT;
      S_SHIFT:
        if (tick && last_edge)
          state_nx = last_r ? S_HOLD : S_NEXT;
      S_HOLD:  if (tick) state_nx = S_GUARD;
      S_GUARD: if (tick) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_last  <= 1'b0;
      rx_data  <= '0;
      spi_cs_n <= '1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
      last_r   <= 1'b0;
      div_r    <= DIV_W'(1);
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_last  <= 1'b0;
      tx_ready <= (state_nx == S_IDLE) ||
                  (state_nx == S_NEXT);
      busy     <= (state_nx != S_IDLE);
      cnt      <= (running && !tick) ?
                  cnt + DIV_W'(1) : '0;

      if (state == S_IDLE) begin
        spi_sclk <= cpol_i;
        spi_cs_n <= '1;
        if (hs) begin
          cpol_r   <= cpol_i;
          cpha_r   <= cpha_i;
          lsb_r    <= lsb_first_i;
          div_r    <= (clk_divisor == '0) ?
                      DIV_W'(1) : clk_divisor;
          spi_cs_n <= cs_dec(cs_sel);
        end
      end

      if (state == S_NEXT)
        spi_sclk <= cpol_r;

      if (load) begin
        last_r  <= tx_last;
        bit_cnt <= '0;
        rx_sh   <= '0;
        if (cpha_sel) begin
          tx_sh <= word_in;
        end else begin
          spi_mosi <= word_in[DATA_W-1];
          tx_sh    <= word_in << 1;
        end
      end

      if ((state == S_SHIFT) && tick) begin
        spi_sclk <= ~spi_sclk;
        bit_cnt  <= bit_cnt + BW'(1);
        rx_sh    <= rx_nx;
        if (drive) begin
          spi_mosi <= tx_sh[DATA_W-1];
          tx_sh    <= tx_sh << 1;
        end
        if (last_edge) begin
          rx_valid <= 1'b1;
          rx_last  <= last_r;
          rx_data  <= lsb_r ? rev(rx_nx) : rx_nx;
        end
      end

      if ((state == S_HOLD) && tick)
        spi_cs_n <= '1;
    end
  end

endmodule

// File: tb/tb_spi_master_burst.sv
// Bench for spi_master_burst: vector table, slave model,
// rx scoreboard, burst, divisor-0, 12-bit and reset-abort cases.
module tb_spi_master_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpol_i = 1'b0, cpha_i = 1'b0;
  logic        lsb_first_i = 1'b0;
  logic [15:0] clk_divisor = 16'd2;
  logic [1:0]  cs_sel = 2'd0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_last = 1'b0, tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_last, busy;
  logic [3:0]  spi_cs_n;
  logic        spi_sclk, spi_mosi, spi_miso;

  logic [11:0] b_tx_data = 12'h000;
  logic        b_tx_valid = 1'b0;
  logic        b_tx_ready;
  logic [11:0] b_rx_data;
  logic        b_rx_valid, b_rx_last, b_busy;
  logic [3:0]  b_cs_n;
  logic        b_sclk, b_mosi;

  always #5 clk = ~clk;

  spi_master_burst #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpol_i(cpol_i), .cpha_i(cpha_i),
    .lsb_first_i(lsb_first_i),
    .clk_divisor(clk_divisor), .cs_sel(cs_sel),
    .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_last(rx_last), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_master_burst #(.DATA_W(12)) dut12 (
    .clk(clk), .rst(rst),
    .cpol_i(1'b0), .cpha_i(1'b0),
    .lsb_first_i(1'b0),
    .clk_divisor(16'd1), .cs_sel(2'd0),
    .tx_data(b_tx_data), .tx_last(1'b1),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_last(b_rx_last), .busy(b_busy),
    .spi_cs_n(b_cs_n), .spi_sclk(b_sclk),
    .spi_mosi(b_mosi), .spi_miso(b_mosi)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Slave model
  bit         use_loop = 1'b1;
  bit         s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  logic       s_miso = 1'b0;
  logic       s_csp = 1'b0, s_sclkp = 1'b0;
  logic       cs_act;
  int         tk = 0, rk = 0;

  assign cs_act   = (spi_cs_n != 4'hF);
  assign spi_miso = use_loop ? spi_mosi : s_miso;

  function automatic logic sbit(input int k);
    return s_lsb ? s_tx[k] : s_tx[7-k];
  endfunction

  always @(spi_sclk or cs_act) begin
    if (cs_act && !s_csp) begin
      tk = 0; rk = 0; s_rx = 8'h00;
      if (!s_cpha) begin
        s_miso = sbit(0); tk = 1;
      end
    end else if (cs_act && spi_sclk !== s_sclkp) begin
      if ((spi_sclk != s_cpol) != s_cpha) begin
        if (rk < 8) begin
          if (s_lsb) s_rx[rk] = spi_mosi;
          else       s_rx[7-rk] = spi_mosi;
          rk++;
        end
      end else if (tk < 8) begin
        s_miso = sbit(tk); tk++;
      end
    end
    s_csp = cs_act;
    s_sclkp = spi_sclk;
  end

  // Pin monitor, sampled on the falling clock edge
  int         cur_gap = 2;
  bit         cur_cpha = 1'b0;
  logic [3:0] cur_cs = 4'hD;
  int cyc = 0, edges = 0, wedge = 0, last_ec = 0;
  int gap_err = 0, mosi_err = 0, cs_bad = 0;
  int cs_low = 0, cs_rise = 0;
  int rx_cnt = 0, last_cnt = 0;
  logic [8:0] obs [0:63];
  logic       m_sclk = 1'b0, m_mosi = 1'b0;
  logic [3:0] m_cs = 4'hF;

  always @(negedge clk) begin
    cyc++;
    if (rst || !busy) begin
      wedge = 0;
    end else begin
      if (spi_sclk !== m_sclk) begin
        if (wedge != 0 && cyc - last_ec != cur_gap)
          gap_err++;
        if (spi_mosi !== m_mosi &&
            wedge[0] == cur_cpha)
          mosi_err++;
        last_ec = cyc;
        edges++;
        wedge = (wedge == 15) ? 0 : wedge + 1;
      end else if (spi_mosi !== m_mosi && wedge != 0) begin
        mosi_err++;
      end
      if (spi_cs_n !== cur_cs && spi_cs_n !== 4'hF)
        cs_bad++;
      if (spi_cs_n === cur_cs) cs_low++;
    end
    if (m_cs !== 4'hF && spi_cs_n === 4'hF) cs_rise++;
    if (rx_valid) begin
      if (rx_cnt < 64) obs[rx_cnt] = {rx_last, rx_data};
      rx_cnt++;
      if (rx_last) last_cnt++;
    end
    m_sclk = spi_sclk;
    m_mosi = spi_mosi;
    m_cs   = spi_cs_n;
  end

  // Stimulus side
  logic [8:0] exp_q [$];

  typedef struct {
    bit         cpol, cpha, lsb, loop;
    logic [15:0] div;
    logic [1:0] sel;
    logic [7:0] tx, stx, exp_rx;
    logic [3:0] exp_cs;
    int         gap;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(
    bit cpol, bit cpha, bit lsb, bit loop,
    int div, int sel, logic [7:0] tx,
    logic [7:0] stx, logic [7:0] er,
    logic [3:0] ecs, int gap);
    vec_t v;
    v.cpol = cpol; v.cpha = cpha; v.lsb = lsb;
    v.loop = loop; v.div = 16'(div);
    v.sel = 2'(sel); v.tx = tx; v.stx = stx;
    v.exp_rx = er; v.exp_cs = ecs; v.gap = gap;
    return v;
  endfunction

  task automatic send_word(input logic [7:0] d,
                           input bit last,
                           input logic [7:0] expd);
    int n = 0;
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    while (!tx_ready && n < 3000) begin
      @(negedge clk); n++;
    end
    if (!tx_ready) begin
      chk("handshake_timeout", 0, 1);
      tx_valid = 1'b0;
    end else begin
      exp_q.push_back({last, expd});
      @(posedge clk);
      #1 tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("burst_end_timeout", busy, 0);
  endtask

  task automatic check_words(input string name,
                             input int base);
    int n = exp_q.size();
    logic [8:0] e;
    chk({name, "_rx_pulses"}, rx_cnt - base, n);
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      if (base + k < rx_cnt && base + k < 64) begin
        chk({name, "_rx_data"}, obs[base+k][7:0], e[7:0]);
        chk({name, "_rx_last"}, obs[base+k][8], e[8]);
      end
    end
    exp_q.delete();
  endtask

  task automatic setup_vec(input vec_t v);
    @(negedge clk);
    cpol_i = v.cpol; cpha_i = v.cpha;
    lsb_first_i = v.lsb; clk_divisor = v.div;
    cs_sel = v.sel; use_loop = v.loop;
    s_cpol = v.cpol; s_cpha = v.cpha;
    s_lsb = v.lsb; s_tx = v.stx;
    cur_gap = v.gap; cur_cpha = v.cpha;
    cur_cs = v.exp_cs;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input string name,
                         input vec_t v);
    int e0, g0, m0, b0, l0, r0, c0, lc0;
    setup_vec(v);
    chk({name, "_idle_sclk"}, spi_sclk, v.cpol);
    e0 = edges; g0 = gap_err; m0 = mosi_err;
    b0 = cs_bad; l0 = cs_low; r0 = rx_cnt;
    c0 = cs_rise; lc0 = last_cnt;
    send_word(v.tx, 1'b1, v.exp_rx);
    wait_idle();
    repeat (2) @(negedge clk);
    chk({name, "_edges"}, edges - e0, 16);
    chk({name, "_edge_gap"}, gap_err - g0, 0);
    chk({name, "_mosi_timing"}, mosi_err - m0, 0);
    chk({name, "_cs_other"}, cs_bad - b0, 0);
    chk({name, "_cs_asserted"}, (cs_low - l0) > 0, 1);
    chk({name, "_cs_release"}, cs_rise - c0, 1);
    chk({name, "_last_pulses"}, last_cnt - lc0, 1);
    check_words(name, r0);
    chk({name, "_cs_after"}, spi_cs_n, 4'hF);
    chk({name, "_sclk_after"}, spi_sclk, v.cpol);
    chk({name, "_ready_after"}, tx_ready, 1);
    if (!v.loop)
      chk({name, "_slave_rx"}, s_rx, v.tx);
  endtask

  initial begin
    int r0, c0, b0, e0, g0, lc0, n;

    tbl[0] = mk(0,0,0,1, 2,1, 8'hA5,8'h00,8'hA5, 4'hD,2);
    tbl[1] = mk(0,1,0,0, 3,0, 8'h3C,8'hC3,8'hC3, 4'hE,3);
    tbl[2] = mk(1,0,0,0, 2,2, 8'h3C,8'hC3,8'hC3, 4'hB,2);
    tbl[3] = mk(1,1,0,0, 1,3, 8'h3C,8'hC3,8'hC3, 4'h7,1);
    tbl[4] = mk(0,0,1,0, 2,1, 8'h01,8'h80,8'h80, 4'hD,2);
    tbl[5] = mk(0,0,0,1, 0,0, 8'h5A,8'h00,8'h5A, 4'hE,1);
    tbl[6] = mk(1,1,1,0, 2,1, 8'h6B,8'h2D,8'h2D, 4'hD,2);

    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs", spi_cs_n, 4'hF);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_last", rx_last, 0);
    chk("rst_rx_data", rx_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Three-word burst with a stalled second word
    setup_vec(tbl[0]);
    r0 = rx_cnt; c0 = cs_rise; b0 = cs_bad;
    e0 = edges; g0 = gap_err; lc0 = last_cnt;
    send_word(8'h11, 1'b0, 8'h11);
    n = 0;
    while (rx_cnt == r0 && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("burst_w1_timeout", rx_cnt - r0, 1);
    cs_sel = 2'd2; cpol_i = 1'b1; lsb_first_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("burst_gap_ready", tx_ready, 1);
    chk("burst_gap_busy", busy, 1);
    chk("burst_gap_cs", spi_cs_n, 4'hD);
    chk("burst_gap_sclk", spi_sclk, 0);
    send_word(8'h22, 1'b0, 8'h22);
    send_word(8'h33, 1'b1, 8'h33);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("burst_edges", edges - e0, 48);
    chk("burst_edge_gap", gap_err - g0, 0);
    chk("burst_cs_other", cs_bad - b0, 0);
    chk("burst_cs_release", cs_rise - c0, 1);
    chk("burst_last_pulses", last_cnt - lc0, 1);
    check_words("burst", r0);
    chk("burst_cs_after", spi_cs_n, 4'hF);

    // 12-bit loopback
    @(negedge clk);
    b_tx_data = 12'hABC; b_tx_valid = 1'b1;
    n = 0;
    while (!b_tx_ready && n < 100) begin
      @(negedge clk); n++;
    end
    @(posedge clk);
    #1 b_tx_valid = 1'b0;
    n = 0;
    while (!b_rx_valid && n < 500) begin
      @(negedge clk); n++;
    end
    chk("w12_rx_valid", b_rx_valid, 1);
    chk("w12_rx_data", b_rx_data, 12'hABC);
    chk("w12_rx_last", b_rx_last, 1);

    // Reset in the middle of a word
    tbl[0].div = 16'd4; tbl[0].gap = 4;
    setup_vec(tbl[0]);
    e0 = edges;
    send_word(8'hC6, 1'b1, 8'hC6);
    n = 0;
    while (edges - e0 < 5 && n < 500) begin
      @(negedge clk); n++;
    end
    chk("abort_reach_shift", (edges - e0) >= 5, 1);
    r0 = rx_cnt;
    #2 rst = 1'b1;
    #1;
    chk("abort_cs", spi_cs_n, 4'hF);
    chk("abort_busy", busy, 0);
    chk("abort_sclk", spi_sclk, 0);
    chk("abort_ready", tx_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_rx", rx_cnt - r0, 0);
    exp_q.delete();
    tbl[0].div = 16'd2; tbl[0].gap = 2;
    run_vec("after_rst", tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
